// File: rtl/mac_pkg.sv
// Shared constants, state encoding and operand-pair payload for the mac vector feeder.
package mac_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = 4;
    localparam int unsigned PTRW  = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_CLR    = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

endpackage

// File: rtl/mac_opbuf.sv
// Operand-pair register file: one synchronous write port, one combinational read port.
module mac_opbuf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ABITS = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ABITS-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/mac_vec_feeder.sv
// Buffers a vector of operand pairs, streams it through an external mac and
// returns the captured dot product on a valid/ready result port.
module mac_vec_feeder
    import mac_pkg::*;
(
    input  logic          clk,
    input  logic          r,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic          in_last,
    output logic          mac_clr,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    input  logic [AW-1:0] mac_acc,
    input  logic          mac_of,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_acc,
    output logic          res_of,
    output logic [LW-1:0] res_len,
    output logic          busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LW-1:0]     r_wptr;
    logic [LW-1:0]     w_wptr_nxt;
    logic [PTRW-1:0]   r_rptr;
    logic [PTRW-1:0]   w_rptr_nxt;
    logic [LW-1:0]     r_res_len;
    logic [LW-1:0]     w_res_len_nxt;
    logic              r_res_valid;
    logic              w_res_valid_nxt;
    logic [AW-1:0]     r_res_acc;
    logic [AW-1:0]     w_res_acc_nxt;
    logic              r_res_of;
    logic              w_res_of_nxt;
    logic              r_in_ready;
    logic              r_busy;

    logic              w_we;
    pair_t             w_wdata;
    pair_t             w_rdata;
    logic              w_mac_clr;
    logic [DW-1:0]     w_mac_a;
    logic [DW-1:0]     w_mac_b;

    mac_opbuf #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DW),
        .ABITS (PTRW)
    ) u_opbuf (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wptr[PTRW-1:0]),
        .wdata (w_wdata),
        .raddr (r_rptr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!r) begin
            r_state     <= ST_LOAD;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_res_len   <= '0;
            r_res_valid <= 1'b0;
            r_res_acc   <= '0;
            r_res_of    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_res_len   <= w_res_len_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_acc   <= w_res_acc_nxt;
            r_res_of    <= w_res_of_nxt;
            r_in_ready  <= (w_state_nxt == ST_LOAD);
            r_busy      <= (w_state_nxt != ST_LOAD);
        end
    end

    // Next-state, pointer and result-capture logic; mac drive is decoded from state.
    always_comb begin
        w_state_nxt     = r_state;
        w_wptr_nxt      = r_wptr;
        w_rptr_nxt      = r_rptr;
        w_res_len_nxt   = r_res_len;
        w_res_valid_nxt = r_res_valid;
        w_res_acc_nxt   = r_res_acc;
        w_res_of_nxt    = r_res_of;
        w_we            = 1'b0;
        w_wdata         = '{a: in_a, b: in_b};
        w_mac_clr       = 1'b0;
        w_mac_a         = '0;
        w_mac_b         = '0;

        case (r_state)
            ST_LOAD: begin
                if (in_valid) begin
                    w_we       = 1'b1;
                    w_wptr_nxt = r_wptr + LW'(1);
                    if (in_last || (r_wptr == LW'(DEPTH - 1))) begin
                        w_res_len_nxt = r_wptr + LW'(1);
                        w_state_nxt   = ST_CLR;
                    end
                end
            end
            ST_CLR: begin
                w_mac_clr   = 1'b1;
                w_rptr_nxt  = '0;
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                w_mac_a = w_rdata.a;
                w_mac_b = w_rdata.b;
                if (LW'(r_rptr) == (r_res_len - LW'(1))) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_rptr_nxt = r_rptr + PTRW'(1);
                end
            end
            ST_WAIT: begin
                // Last product lands in the accumulator at the edge opening this cycle.
                w_res_acc_nxt   = mac_acc;
                w_res_of_nxt    = mac_of;
                w_res_valid_nxt = 1'b1;
                w_state_nxt     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_wptr_nxt      = '0;
                    w_state_nxt     = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // The mac must see its clear on the very edge that resets the feeder.
    assign mac_clr   = w_mac_clr | ~r;
    assign mac_a     = w_mac_a;
    assign mac_b     = w_mac_b;
    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign res_valid = r_res_valid;
    assign res_acc   = r_res_acc;
    assign res_of    = r_res_of;
    assign res_len   = r_res_len;

endmodule
